// File: rtl/seq_alu_pipe.sv
// Nibble-serial ALU: loads A, B and an opcode as NIB-bit beats, then streams the WIDTH-bit result back LSB nibble first.
// Result beat 0 is valid 2 cycles after the opcode handshake; input and output never overlap, and out_data holds while out_ready is low.
module seq_alu_pipe #(
  parameter int WIDTH = 8,
  parameter int NIB   = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [NIB-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [NIB-1:0] out_data,
  output logic [4:0]     flags,
  output logic           busy
);

  localparam int N  = WIDTH / NIB;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int M  = WIDTH - 1;
  localparam logic [CW-1:0]    LAST = CW'(N - 1);
  localparam logic [WIDTH-1:0] WV   = WIDTH'(WIDTH);

  typedef enum logic [2:0] {LOAD_A, LOAD_B, LOAD_OP, EXEC, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a, b, shreg;
  logic [3:0]       opcode;
  logic             cflag;
  logic             in_take, out_take;

  logic             cin, cy, ov, err;
  logic [WIDTH-1:0] s, alu_r, flag_v;
  logic [WIDTH:0]   add_r, sub_r, shl_r, shr_r, sar_r;
  logic             add_ov, sub_ov;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= LOAD_A;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      LOAD_A: begin
        in_ready = 1'b1;
        if (in_valid && cnt == LAST) state_nxt = LOAD_B;
      end
      LOAD_B: begin
        in_ready = 1'b1;
        if (in_valid && cnt == LAST) state_nxt = LOAD_OP;
      end
      LOAD_OP: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = EXEC;
      end
      EXEC: state_nxt = DRAIN;
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && cnt == LAST) state_nxt = LOAD_A;
      end
      default: state_nxt = LOAD_A;
    endcase
  end

  assign in_take  = in_valid && in_ready;
  assign out_take = out_valid && out_ready;
  assign out_data = shreg[NIB-1:0];
  assign busy     = !(state == LOAD_A && cnt == '0);

  // Borrow-in shares the carry path: SBB subtracts C, ADC adds it.
  always_comb begin
    cin = (opcode == 4'hB || opcode == 4'hC) ? cflag : 1'b0;
    s     = b % WV;
    add_r = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
    sub_r = {1'b0, a} - {1'b0, b} - (WIDTH+1)'(cin);
    shl_r = {1'b0, a} << s;
    shr_r = {a, 1'b0} >> s;
    sar_r = $signed({a, 1'b0}) >>> s;
    add_ov = (a[M] == b[M]) && (add_r[M] != a[M]);
    sub_ov = (a[M] != b[M]) && (sub_r[M] != a[M]);
    alu_r = '0;
    cy    = 1'b0;
    ov    = 1'b0;
    err   = 1'b0;
    case (opcode)
      4'h0, 4'hB: begin alu_r = add_r[M:0]; cy = add_r[WIDTH]; ov = add_ov; end
      4'h1, 4'hC: begin alu_r = sub_r[M:0]; cy = sub_r[WIDTH]; ov = sub_ov; end
      4'h2: alu_r = a & b;
      4'h3: alu_r = a | b;
      4'h4: alu_r = a ^ b;
      4'h5: alu_r = ~a;
      4'h6: alu_r = ~(a & b);
      4'h7: alu_r = ~(a | b);
      // The extra guard bit catches the last bit shifted out; it stays 0 for s=0.
      4'h8: begin alu_r = shl_r[M:0];     cy = shl_r[WIDTH]; end
      4'h9: begin alu_r = shr_r[WIDTH:1]; cy = shr_r[0];     end
      4'hA: begin alu_r = sar_r[WIDTH:1]; cy = sar_r[0];     end
      4'hD: begin alu_r = a; cy = sub_r[WIDTH]; ov = sub_ov; end
      4'hE: alu_r = b;
      default: err = 1'b1;
    endcase
    // CMP reports sign/zero of the subtraction, not of the passed-through A.
    flag_v = (opcode == 4'hD) ? sub_r[M:0] : alu_r;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      a      <= '0;
      b      <= '0;
      shreg  <= '0;
      opcode <= '0;
      flags  <= '0;
      cflag  <= 1'b0;
    end else begin
      if ((in_take && state != LOAD_OP) || out_take)
        cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
      if (in_take && state == LOAD_A) a[cnt*NIB +: NIB] <= in_data;
      if (in_take && state == LOAD_B) b[cnt*NIB +: NIB] <= in_data;
      if (in_take && state == LOAD_OP) opcode <= in_data[3:0];
      if (state == EXEC) begin
        shreg <= alu_r;
        flags <= {err, flag_v[M], flag_v == '0, cy, ov};
        cflag <= cy;
      end else if (out_take) begin
        shreg <= shreg >> NIB;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu_pipe.sv
// Bench for seq_alu_pipe: an 8-bit and a 16-bit instance share one stream driver, selected by sel,
// checked against an integer-arithmetic reference model.
module tb_seq_alu_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, sel, in_valid, out_ready;
  logic [3:0] in_data;
  logic       r8, v8, b8, r16, v16, b16;
  logic [3:0] d8, d16;
  logic [4:0] f8, f16;
  logic       in_ready, out_valid, busy;
  logic [3:0] out_data;
  logic [4:0] flags;

  int checks = 0, errors = 0;
  int cm [2];

  seq_alu_pipe #(.WIDTH(8), .NIB(4)) u8 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid & ~sel), .in_ready(r8),
    .in_data(in_data), .out_valid(v8), .out_ready(out_ready & ~sel), .out_data(d8),
    .flags(f8), .busy(b8));

  seq_alu_pipe #(.WIDTH(16), .NIB(4)) u16 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid & sel), .in_ready(r16),
    .in_data(in_data), .out_valid(v16), .out_ready(out_ready & sel), .out_data(d16),
    .flags(f16), .busy(b16));

  assign in_ready  = sel ? r16 : r8;
  assign out_valid = sel ? v16 : v8;
  assign out_data  = sel ? d16 : d8;
  assign flags     = sel ? f16 : f8;
  assign busy      = sel ? b16 : b8;

  function automatic void ref_op(input int w, input int op, input longint a, input longint b,
                                 input int c, output longint res, output logic [4:0] fl);
    longint m, h, sa, sb, sr, fv;
    int s, ci;
    bit cy, ov, er;
    m = (longint'(1) << w) - 1;
    h = longint'(1) << (w - 1);
    sa = (a >= h) ? a - (m + 1) : a;
    sb = (b >= h) ? b - (m + 1) : b;
    s = int'(b % w);
    cy = 0; ov = 0; er = 0; res = 0; fv = 0;
    case (op)
      0, 11: begin
        ci = (op == 11) ? c : 0;
        res = (a + b + ci) & m;
        cy = (a + b + ci) > m;
        sr = sa + sb + ci;
        ov = (sr > h - 1) || (sr < -h);
      end
      1, 12, 13: begin
        ci = (op == 12) ? c : 0;
        res = (a - b - ci) & m;
        cy = a < b + ci;
        sr = sa - sb - ci;
        ov = (sr > h - 1) || (sr < -h);
      end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = ~a & m;
      6: res = ~(a & b) & m;
      7: res = ~(a | b) & m;
      8: begin res = (a << s) & m; cy = (s != 0) && (((a >> (w - s)) & 1) != 0); end
      9: begin res = a >> s;       cy = (s != 0) && (((a >> (s - 1)) & 1) != 0); end
      10: begin res = (sa >>> s) & m; cy = (s != 0) && (((a >> (s - 1)) & 1) != 0); end
      14: res = b;
      default: begin res = 0; er = 1; end
    endcase
    fv = res;
    if (op == 13) res = a;
    fl = {er, ((fv >> (w - 1)) & 1) != 0, fv == 0, cy, ov};
  endfunction

  task automatic send(input logic [3:0] d);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input longint v, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      send(4'((v >> (4 * i)) & 15));
    end
  endtask

  task automatic recv(input int n, input bit stall, output longint r);
    r = 0;
    for (int i = 0; i < n; i++) begin
      int t;
      bit got;
      t = 0;
      got = 0;
      while (!got && t < 100) begin
        out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        if (out_valid && out_ready) begin
          r |= longint'(out_data) << (4 * i);
          got = 1;
        end
        @(negedge clk);
        t++;
      end
      out_ready = 1'b0;
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL recv_timeout beat=%0d out_valid=%0b required=1", i, out_valid);
      end
    end
  endtask

  task automatic run_txn(input string name, input longint a, input longint b, input int op, input bit rnd);
    int w, n;
    longint er, r;
    logic [4:0] ef;
    w = sel ? 16 : 8;
    n = w / 4;
    ref_op(w, op, a, b, cm[sel], er, ef);
    cm[sel] = int'(ef[1]);
    send_word(a, n, rnd);
    send_word(b, n, rnd);
    send(4'(op));
    recv(n, rnd, r);
    checks++;
    if (r !== er) begin
      errors++;
      $display("FAIL %s_result a=%0h b=%0h op=%0h got=%0h required=%0h", name, a, b, op, r, er);
    end
    checks++;
    if (flags !== ef) begin
      errors++;
      $display("FAIL %s_flags a=%0h b=%0h op=%0h got=%b required=%b", name, a, b, op, flags, ef);
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if ({in_ready, out_valid, out_data, busy, flags} !== {1'b1, 1'b0, 4'h0, 1'b0, 5'h00}) begin
      errors++;
      $display("FAIL %s got rdy=%0b vld=%0b dat=%0h busy=%0b flags=%b required 1 0 0 0 00000",
               name, in_ready, out_valid, out_data, busy, flags);
    end
  endtask

  task automatic test_reset();
    check_idle("reset_asserted");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_idle("reset_released");
  endtask

  task automatic test_directed();
    run_txn("add_carry", 'hF0, 'h20, 0, 0);
    run_txn("add_ovf",   'h7F, 'h01, 0, 0);
    run_txn("adc_zero",  'h00, 'h00, 11, 0);
    run_txn("sub_borrow",'h10, 'h20, 1, 0);
    run_txn("sbb",       'h05, 'h01, 12, 0);
    run_txn("sar",       'h80, 'h03, 10, 0);
    run_txn("shr",       'h80, 'h03, 9, 0);
    run_txn("shl_mod",   'h80, 'h08, 8, 0);
    run_txn("cmp_eq",    'h42, 'h42, 13, 0);
    run_txn("not",       'h3C, 'h00, 5, 0);
  endtask

  task automatic test_latency_stall();
    longint er, r;
    logic [4:0] ef;
    logic [3:0] d0;
    ref_op(8, 4, 'h3C, 'h5A, cm[0], er, ef);
    cm[0] = int'(ef[1]);
    send_word('h3C, 2, 0);
    send_word('h5A, 2, 0);
    send(4'h4);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL exec_cycle out_valid=%0b in_ready=%0b required 0 0", out_valid, in_ready);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency out_valid=%0b required=1", out_valid);
    end
    d0 = out_data;
    checks++;
    if (d0 !== 4'(er & 15)) begin
      errors++;
      $display("FAIL first_beat got=%0h required=%0h", d0, er & 15);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== d0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d vld=%0b dat=%0h rdy=%0b required 1 %0h 0",
                 i, out_valid, out_data, in_ready, d0);
      end
    end
    recv(2, 0, r);
    checks++;
    if (r !== er) begin
      errors++;
      $display("FAIL stall_result got=%0h required=%0h", r, er);
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_drain in_ready=%0b out_valid=%0b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    send(4'h3);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_load got=%0b required=1", busy);
    end
    send(4'h1);
    send(4'h7);
    reset_n = 1'b0;
    #1;
    check_idle("reset_mid");
    cm[0] = 0;
    cm[1] = 0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_txn("post_reset_add", 'h01, 'h01, 0, 0);
    run_txn("reserved", 'hA5, 'h5A, 15, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++)
      run_txn("rand8", longint'($urandom_range(0, 255)), longint'($urandom_range(0, 255)),
              int'($urandom_range(0, 15)), 1);
  endtask

  task automatic test_wide();
    sel = 1'b1;
    @(negedge clk);
    run_txn("w16_add", 'h00F0, 'h0020, 0, 0);
    run_txn("w16_sar", 'h8000, 'h0013, 10, 0);
    for (int i = 0; i < 20; i++)
      run_txn("rand16", longint'($urandom_range(0, 65535)), longint'($urandom_range(0, 65535)),
              int'($urandom_range(0, 15)), 1);
    sel = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    sel = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = 4'h0;
    cm[0] = 0;
    cm[1] = 0;
    repeat (2) @(negedge clk);
    test_reset();
    test_directed();
    test_latency_stall();
    test_reset_mid();
    test_random();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
